// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the CPU requester port, the DMA requester port and the shared
//   memory port of mem_arbiter.
//
//   cpu_req/we/addr/wdata  requester -> arbiter, held until cpu_gnt
//   cpu_gnt                arbiter -> requester, combinational grant
//   cpu_rdata/cpu_valid    arbiter -> requester, read return (1-cycle pulse)
//   dma_*                  same as cpu_* for the DMA/debug loader
//   mem_addr/wdata         arbiter -> memory, registered
//   mem_read_en/mem_we     arbiter -> memory, registered strobes
//   mem_rdata              memory -> arbiter, valid while mem_read_en is high
//
//   Modports: slave  = arbiter view, master = harness/requester/memory view.
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_valid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_valid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_valid,
        output mem_addr, mem_wdata, mem_read_en, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_valid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_valid,
        input  mem_addr, mem_wdata, mem_read_en, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the CPU core and a DMA/debug loader.
//   The CPU wins contention by default; after STARVE_LIMIT consecutive lost
//   contention cycles the DMA is promoted for up to MAX_BURST grants.
//   One access per cycle; read data returns to the owning requester two
//   cycles after its handshake cycle.
//
//   ph1    clock, all state updates on the rising edge
//   reset  asynchronous, active-high
//   bus    mem_arbiter_if.slave (CPU port, DMA port, memory port)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 3,   // 1..15
    parameter int MAX_BURST    = 2    // 1..15
) (
    input  logic         ph1,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [3:0]  burst_cnt, burst_nxt;

    logic        cpu_gnt_c, dma_gnt_c;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              read_en_q;   // doubles as the registered is_read flag
    logic              we_q;
    logic              owner_dma_q; // owner tag of the access on the bus
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              cpu_valid_q, dma_valid_q;

    // ------------------------------------------------------------------
    // Grant: a single requester always wins; on contention the state
    // decides. Both grants are forced low while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cpu_gnt_c = 1'b0;
        dma_gnt_c = 1'b0;
        if (!reset) begin
            if (bus.cpu_req && bus.dma_req) begin
                if (state == DMA_PRI) dma_gnt_c = 1'b1;
                else                  cpu_gnt_c = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.dma_req) begin
                dma_gnt_c = 1'b1;
            end
        end
    end

    assign bus.cpu_gnt = cpu_gnt_c;
    assign bus.dma_gnt = dma_gnt_c;

    // ------------------------------------------------------------------
    // Priority FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        burst_nxt  = burst_cnt;
        case (state)
            CPU_PRI: begin
                if (bus.dma_req && cpu_gnt_c) begin
                    // Lost contention; promote on the edge the count would
                    // reach the limit.
                    if (starve_cnt + 4'd1 >= 4'(STARVE_LIMIT)) begin
                        state_nxt  = DMA_PRI;
                        starve_nxt = 4'd0;
                        burst_nxt  = 4'd0;
                    end else begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end else begin
                    // DMA either got the port or is not asking.
                    starve_nxt = 4'd0;
                end
            end
            DMA_PRI: begin
                if (!bus.dma_req) begin
                    // Covers the CPU-only handshake case as well.
                    state_nxt = CPU_PRI;
                    burst_nxt = 4'd0;
                end else if (dma_gnt_c) begin
                    if (burst_cnt + 4'd1 >= 4'(MAX_BURST)) begin
                        state_nxt = CPU_PRI;
                        burst_nxt = 4'd0;
                    end else begin
                        burst_nxt = burst_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt  = CPU_PRI;
                starve_nxt = 4'd0;
                burst_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state      <= CPU_PRI;
            starve_cnt <= 4'd0;
            burst_cnt  <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory request stage (edge T) and read return stage (edge T+1).
    // Clearing read_en_q on reset drops any pending read return.
    // ------------------------------------------------------------------
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            read_en_q   <= 1'b0;
            we_q        <= 1'b0;
            owner_dma_q <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            read_en_q   <= 1'b0;
            we_q        <= 1'b0;
            owner_dma_q <= dma_gnt_c;
            if (cpu_gnt_c) begin
                addr_q    <= bus.cpu_addr;
                wdata_q   <= bus.cpu_wdata;
                read_en_q <= !bus.cpu_we;
                we_q      <= bus.cpu_we;
            end else if (dma_gnt_c) begin
                addr_q    <= bus.dma_addr;
                wdata_q   <= bus.dma_wdata;
                read_en_q <= !bus.dma_we;
                we_q      <= bus.dma_we;
            end

            cpu_valid_q <= read_en_q && !owner_dma_q;
            dma_valid_q <= read_en_q &&  owner_dma_q;
            if (read_en_q && !owner_dma_q) cpu_rdata_q <= bus.mem_rdata;
            if (read_en_q &&  owner_dma_q) dma_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_read_en = read_en_q;
    assign bus.mem_we      = we_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_valid   = cpu_valid_q;
    assign bus.dma_rdata   = dma_rdata_q;
    assign bus.dma_valid   = dma_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed stimulus with hand-written grant expectations. The driver checks
//   grants and queues the expected memory-bus transaction and read return;
//   a monitor on the falling edge pops and compares whenever the DUT shows
//   a bus strobe or a valid pulse.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic ph1   = 1'b0;
    logic reset = 1'b1;

    always #5 ph1 = ~ph1;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(3), .MAX_BURST(2)
    ) dut (
        .ph1  (ph1),
        .reset(reset),
        .bus  (bus)
    );

    // Memory model: 0x1234 holds 0xA5, every other word is hi^lo byte.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[15:8] ^ a[7:0];
    endfunction

    assign bus.mem_rdata = bus.mem_read_en ? mem_model(bus.mem_addr) : 8'h00;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] dma_q[$];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_CPU  = 2'd1;
    localparam logic [1:0] G_DMA  = 2'd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic drive(
        input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
        input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
        input logic [1:0] exp_g, input string name
    );
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
        @(negedge ph1);
        check({name, "_gnt"}, {30'd0, bus.dma_gnt, bus.cpu_gnt}, {30'd0, exp_g});
        if (exp_g == G_CPU) begin
            bus_q.push_back('{addr: ca, wdata: cd, we: cw});
            if (!cw) cpu_q.push_back(mem_model(ca));
        end else if (exp_g == G_DMA) begin
            bus_q.push_back('{addr: da, wdata: dd, we: dw});
            if (!dw) dma_q.push_back(mem_model(da));
        end
        @(posedge ph1);
        #1;
    endtask

    task automatic idle(input string name);
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, G_NONE, name);
    endtask

    // Both requesters reading; grants follow pattern (bit i set = DMA).
    task automatic contend(input int n, input logic [15:0] pat, input string name);
        logic [7:0] ci = 8'd0;
        logic [7:0] di = 8'd0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, {8'h11, ci}, 8'h00, 1'b1, 1'b0, {8'h22, di}, 8'h00,
                  pat[i] ? G_DMA : G_CPU, name);
            if (pat[i]) di++; else ci++;
        end
    endtask

    // Scoreboard monitor
    always @(negedge ph1) begin
        if (!reset) begin
            if (bus.mem_read_en || bus.mem_we) begin
                if (bus_q.size() == 0) unexpected("mem_bus");
                else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    check("mem_addr",  {16'd0, bus.mem_addr}, {16'd0, e.addr});
                    check("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.wdata});
                    check("mem_strobe", {30'd0, bus.mem_read_en, bus.mem_we},
                          {30'd0, !e.we, e.we});
                end
            end
            if (bus.cpu_valid) begin
                if (cpu_q.size() == 0) unexpected("cpu_valid");
                else check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, cpu_q.pop_front()});
            end
            if (bus.dma_valid) begin
                if (dma_q.size() == 0) unexpected("dma_valid");
                else check("dma_rdata", {24'd0, bus.dma_rdata}, {24'd0, dma_q.pop_front()});
            end
        end
    end

    initial begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0; bus.dma_wdata = 8'h0;

        // Reset state, with both requests high to show grants are gated.
        repeat (2) @(negedge ph1);
        check("rst_gnt", {30'd0, bus.dma_gnt, bus.cpu_gnt}, 32'd0);
        check("rst_outs", {bus.mem_addr, bus.mem_wdata, bus.mem_read_en, bus.mem_we,
                           bus.cpu_valid, bus.dma_valid, 4'd0}, 32'd0);
        check("rst_rdata", {16'd0, bus.cpu_rdata, bus.dma_rdata}, 32'd0);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        reset = 1'b0;
        @(posedge ph1);
        #1;

        // Single CPU read of 0x1234 -> 0xA5 two cycles later.
        drive(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, G_CPU, "single");
        repeat (3) idle("single_idle");

        // DMA write alone; no valid pulse; address/data hold afterwards.
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0200, 8'h3C, G_DMA, "dmaw");
        idle("dmaw_idle");
        check("hold_addr",  {16'd0, bus.mem_addr}, 32'h0200);
        check("hold_wdata", {24'd0, bus.mem_wdata}, 32'h3C);
        check("hold_strobe", {30'd0, bus.mem_read_en, bus.mem_we}, 32'd0);
        idle("dmaw_idle2");

        // Continuous contention: C C C D D C C C D D.
        contend(10, 16'b0000_0011_0001_1000, "contend");
        repeat (2) idle("contend_idle");

        // DMA drop: promote, one DMA grant, DMA drops -> back to CPU_PRI
        // with starve_cnt cleared (three more CPU wins before DMA).
        contend(4, 16'b1000, "drop_in");
        drive(1'b1, 1'b0, 16'h1150, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, G_CPU, "drop_cpu");
        contend(4, 16'b1000, "drop_after");
        repeat (2) idle("drop_idle");

        // Starvation clear: two losses, CPU drops, DMA wins immediately and
        // the state stays CPU_PRI with starve_cnt = 0.
        contend(2, 16'b00, "starve_in");
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h2260, 8'h00, G_DMA, "starve_dma");
        contend(4, 16'b1000, "starve_after");
        repeat (2) idle("starve_idle");

        // Reset after a CPU read handshake (with one lost DMA contention).
        drive(1'b1, 1'b0, 16'h1300, 8'h00, 1'b1, 1'b0, 16'h2300, 8'h00, G_CPU, "rst_hs");
        #2;
        reset = 1'b1;
        #1;
        check("midrst_gnt", {30'd0, bus.dma_gnt, bus.cpu_gnt}, 32'd0);
        check("midrst_outs", {bus.mem_addr, bus.mem_wdata, bus.mem_read_en, bus.mem_we,
                              bus.cpu_valid, bus.dma_valid, 4'd0}, 32'd0);
        bus_q.delete();
        cpu_q.delete();
        dma_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1);
            check("midrst_valid", {30'd0, bus.cpu_valid, bus.dma_valid}, 32'd0);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        reset = 1'b0;
        @(posedge ph1);
        #1;
        check("postrst_valid", {30'd0, bus.cpu_valid, bus.dma_valid}, 32'd0);
        // Post-reset: CPU_PRI with a fresh starvation count.
        contend(5, 16'b11000, "postrst");

        // Drain and make sure every expected transaction was seen.
        repeat (4) idle("drain");
        check("drain_bus", bus_q.size(), 32'd0);
        check("drain_cpu", cpu_q.size(), 32'd0);
        check("drain_dma", dma_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit-data, 16-bit-address memory port (mem) between the CPU core (chip) and a DMA/debug loader requester.
- Sits between both masters and mem in the top-level test harness.
- The CPU has default priority; a starvation counter plus a bounded DMA burst window guarantee DMA forward progress.
- One access per cycle throughput. Read data is routed back to the owning requester with a fixed latency.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- STARVE_LIMIT, 3, consecutive lost-contention cycles before DMA is promoted (legal range 1..15).
- MAX_BURST, 2, maximum consecutive DMA grants while promoted (legal range 1..15).

Ports:
- ph1  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; req/addr/we/wdata held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; the handshake completes at the edge where req&&gnt.
- cpu_rdata  out  DATA_W  returned read data.
- cpu_valid  out  1  one-cycle pulse; cpu_rdata is valid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rdata, dma_valid: same meanings as the cpu_* ports, for the DMA port.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_read_en  out  1  registered; memory drives mem_rdata this cycle.
- mem_we  out  1  registered write strobe.
- mem_rdata  in  DATA_W  memory read data, valid in the same cycle as mem_read_en.

Behaviour:
- Reset (asynchronous):
  - state = CPU_PRI; starve_cnt = 0; burst_cnt = 0.
  - mem_read_en, mem_we, cpu_valid and dma_valid = 0.
  - mem_addr, mem_wdata, cpu_rdata and dma_rdata = 0.
  - While reset is high, cpu_gnt and dma_gnt = 0.
- Grant logic (combinational):
  - Only one req high: that requester gets gnt.
  - Both high, state CPU_PRI: cpu_gnt.
  - Both high, state DMA_PRI: dma_gnt.
  - At most one gnt is high per cycle.
- Handshake at edge T (req&&gnt):
  - The selected addr/wdata/we load into the mem_* registers.
  - Read: mem_read_en = 1, mem_we = 0. Write: mem_we = 1, mem_read_en = 0.
  - An owner tag (CPU/DMA) and an is_read flag are registered alongside.
- No handshake at edge T: mem_read_en = mem_we = 0 in the following cycle; mem_addr and mem_wdata hold their values.
- Read return:
  - At edge T+1, mem_rdata is captured into the owner's rdata register, and the owner's valid pulses high for the cycle T+1..T+2.
  - Net latency: valid is asserted 2 cycles after the handshake cycle.
  - The non-owner's rdata holds; writes produce no valid.
- Back-to-back handshakes are legal every cycle for either requester. Returns stay in order; there is no overlap conflict because each stage is one deep.
- State machine:
  - CPU_PRI:
    - starve_cnt += 1 on each edge where dma_req && cpu_gnt (lost contention); saturates at STARVE_LIMIT.
    - starve_cnt clears on a DMA handshake or when dma_req = 0.
    - On the edge where starve_cnt would reach STARVE_LIMIT: go to DMA_PRI, clear starve_cnt and burst_cnt.
  - DMA_PRI:
    - burst_cnt += 1 on each DMA handshake.
    - Return to CPU_PRI on the edge of the MAX_BURST-th DMA handshake, or on any edge with dma_req = 0. burst_cnt clears on return.
    - A CPU handshake in DMA_PRI is only possible with dma_req = 0; it also returns the FSM to CPU_PRI.
- Reset mid-operation: pending read returns are dropped, no valid is asserted, and the bus is idled immediately.
- Counters are 4 bits wide; there is no wrap (saturation or clear only).

Test Plan:
- Single access: cpu_req=1, read addr 0x1234, mem_rdata=0xA5 -> cpu_gnt=1 in cycle 0; mem_addr=0x1234, mem_read_en=1 in cycle 1; cpu_valid=1, cpu_rdata=0xA5 in cycle 2; dma_valid stays 0.
- DMA write alone: dma_req=1, we=1, addr 0x0200, wdata 0x3C -> dma_gnt in cycle 0; cycle 1 has mem_we=1, mem_addr=0x0200, mem_wdata=0x3C; no valid pulses.
- Continuous contention (defaults), both req held high for 10 cycles -> grant sequence C C C D D C C C D D. Data returns to the correct port with addresses distinct per requester.
- DMA drop: enter DMA_PRI, dma_req deasserts after 1 DMA grant -> the next cycle is CPU_PRI; cpu_gnt on the next contention; starve_cnt = 0.
- Starvation clear: in CPU_PRI, two lost contentions (starve_cnt=2), then cpu_req drops -> DMA granted immediately; starve_cnt = 0; state stays CPU_PRI.
- Reset after a CPU read handshake at cycle 0, reset asserted during cycle 1 -> cpu_valid never pulses; all mem_* outputs = 0; post-reset state CPU_PRI.
